// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered at grant, the ALU result is captured after one cycle, and the response is returned tagged with the requester id.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zerof,
    input  logic             alu_negf,
    input  logic             alu_overf,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zerof,
    output logic             rsp_negf,
    output logic             rsp_overf,
    output logic             rsp_carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             grant;
    logic             id_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [OPW-1:0]   op_r;

    // With both requesting, the one not served last wins; otherwise the sole requester.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end
    end

    // Gated by rst_n so neither port sees ready while reset is held.
    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid && grant;

    assign alu_a  = a_r;
    assign alu_b  = b_r;
    assign alu_op = op_r;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_r       <= 1'b0;
            a_r        <= '0;
            b_r        <= '0;
            op_r       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_out    <= '0;
            rsp_zerof  <= 1'b0;
            rsp_negf   <= 1'b0;
            rsp_overf  <= 1'b0;
            rsp_carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        a_r   <= req0_a;
                        b_r   <= req0_b;
                        op_r  <= req0_op;
                        id_r  <= 1'b0;
                        state <= EXEC;
                    end else if (req1_ready) begin
                        a_r   <= req1_a;
                        b_r   <= req1_b;
                        op_r  <= req1_op;
                        id_r  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_out    <= alu_out;
                    rsp_zerof  <= alu_zerof;
                    rsp_negf   <= alu_negf;
                    rsp_overf  <= alu_overf;
                    rsp_carry  <= alu_carry;
                    rsp_id     <= id_r;
                    rsp_valid  <= 1'b1;
                    last_grant <= id_r;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a behavioural ALU drives the shared ALU port,
// and a transaction-level reference predicts grants and tagged responses.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [OPW-1:0]   req0_op = '0, req1_op = '0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [OPW-1:0]   alu_op;
    logic             alu_zerof, alu_negf, alu_overf, alu_carry;
    logic             rsp_valid, rsp_id, busy;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_out;
    logic             rsp_zerof, rsp_negf, rsp_overf, rsp_carry;

    int n_checks = 0;
    int n_pass   = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .alu_zerof(alu_zerof), .alu_negf(alu_negf), .alu_overf(alu_overf), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_zerof(rsp_zerof), .rsp_negf(rsp_negf), .rsp_overf(rsp_overf), .rsp_carry(rsp_carry),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Result layout: {carry, overflow, negative, zero, result[31:0]}.
    function automatic logic [35:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd3: begin s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd4: r = a ^ b;
            3'd5: r = ~(a | b);
            3'd6: r = a;
            default: r = b;
        endcase
        return {c, v, r[31], (r == 32'd0), r};
    endfunction

    assign {alu_carry, alu_overf, alu_negf, alu_zerof, alu_out} = alu_ref(alu_op, alu_a, alu_b);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'hDEADBEEF; req1_b = 32'h12345678; req0_op = 3'd2;
        #2;
        n_checks++;
        if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0000)
            $display("FAIL reset_ctrl: got busy/rspv/rdy0/rdy1=%b want 0000", {busy, rsp_valid, req0_ready, req1_ready});
        else n_pass++;
        n_checks++;
        if ({rsp_out, rsp_id, rsp_zerof, rsp_negf, rsp_overf, rsp_carry} !== 37'd0)
            $display("FAIL reset_rsp: got out=%h id=%b flags=%b want all 0", rsp_out, rsp_id, {rsp_zerof, rsp_negf, rsp_overf, rsp_carry});
        else n_pass++;
        n_checks++;
        if ({alu_a, alu_b, alu_op} !== 67'd0)
            $display("FAIL reset_alu: got a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy, req0_ready, req1_ready} !== 3'b000)
            $display("FAIL reset_held: got busy/rdy0/rdy1=%b want 000", {busy, req0_ready, req1_ready});
        else n_pass++;
        clear_inputs();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'hF0F0F0F0; req0_b = 32'h0F0F0F0F; req0_op = 3'd0;
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL single_grant: got rdy0/rdy1=%b want 10", {req0_ready, req1_ready});
        else n_pass++;
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req0_ready, busy, rsp_valid} !== 3'b010)
            $display("FAIL single_exec: got rdy0/busy/rspv=%b want 010", {req0_ready, busy, rsp_valid});
        else n_pass++;
        n_checks++;
        if ({alu_a, alu_b, alu_op} !== {32'hF0F0F0F0, 32'h0F0F0F0F, 3'd0})
            $display("FAIL single_alu_drive: got a=%h b=%h op=%h want f0f0f0f0 0f0f0f0f 0", alu_a, alu_b, alu_op);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_out, rsp_zerof, rsp_negf, rsp_overf, rsp_carry} !== {1'b1, 1'b0, 32'h0, 4'b1000})
            $display("FAIL single_rsp: got v=%b id=%b out=%h zncv=%b want v=1 id=0 out=00000000 zncv=1000",
                     rsp_valid, rsp_id, rsp_out, {rsp_zerof, rsp_negf, rsp_overf, rsp_carry});
        else n_pass++;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy, rsp_zerof, rsp_out} !== {3'b001, 32'h0})
            $display("FAIL single_after: got v=%b busy=%b z=%b out=%h want v=0 busy=0 z=1 out=0", rsp_valid, busy, rsp_zerof, rsp_out);
        else n_pass++;
        rsp_ready = 1'b0;
    endtask

    task automatic test_alternate();
        int          gq[$];
        int          rq[$];
        int          tq[$];
        logic [31:0] eq[$];
        logic [31:0] oq[$];
        logic [35:0] r;
        logic        h0, h1;
        int          cyc;
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
        cyc = 0;
        while (rq.size() < 6 && cyc < 60) begin
            @(negedge clk);
            h0 = req0_ready;
            h1 = req1_ready;
            if (h0) begin gq.push_back(0); r = alu_ref(req0_op, req0_a, req0_b); eq.push_back(r[31:0]); end
            if (h1) begin gq.push_back(1); r = alu_ref(req1_op, req1_a, req1_b); eq.push_back(r[31:0]); end
            if (rsp_valid) begin rq.push_back(int'(rsp_id)); tq.push_back(cyc); oq.push_back(rsp_out); end
            step();
            if (h0) begin req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7)); end
            if (h1) begin req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7)); end
            cyc++;
        end
        n_checks++;
        if (rq.size() != 6 || gq.size() < 6)
            $display("FAIL alt_count: got %0d responses %0d grants want 6 and >=6 within 60 cycles", rq.size(), gq.size());
        else n_pass++;
        for (int i = 0; i < rq.size() && i < gq.size(); i++) begin
            n_checks++;
            if (gq[i] != (i % 2) || rq[i] != (i % 2) || oq[i] !== eq[i])
                $display("FAIL alt_op%0d: got grant=%0d id=%0d out=%h want grant=%0d id=%0d out=%h",
                         i, gq[i], rq[i], oq[i], i % 2, i % 2, eq[i]);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (tq[i] - tq[i-1] != 3)
                    $display("FAIL alt_spacing%0d: got %0d cycles want 3", i, tq[i] - tq[i-1]);
                else n_pass++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [35:0] e;
        logic [35:0] held;
        logic        held_id;
        logic        seen;
        do_reset();
        req0_valid = 1'b1; req0_a = 32'h7FFFFFFF; req0_b = 32'h00000001; req0_op = 3'd2;
        req1_valid = 1'b1; req1_a = 32'h00000005; req1_b = 32'h00000009; req1_op = 3'd3;
        e = alu_ref(3'd2, 32'h7FFFFFFF, 32'h00000001);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        n_checks++;
        if (!seen || rsp_id !== 1'b0 || {rsp_carry, rsp_overf, rsp_negf, rsp_zerof, rsp_out} !== e)
            $display("FAIL bp_first: got v=%b id=%b cvnz=%b out=%h want v=1 id=0 cvnz=%b out=%h",
                     seen, rsp_id, {rsp_carry, rsp_overf, rsp_negf, rsp_zerof}, rsp_out, e[35:32], e[31:0]);
        else n_pass++;
        held = {rsp_carry, rsp_overf, rsp_negf, rsp_zerof, rsp_out};
        held_id = rsp_id;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({rsp_valid, req0_ready, req1_ready, rsp_id, rsp_carry, rsp_overf, rsp_negf, rsp_zerof, rsp_out} !== {3'b100, held_id, held})
                $display("FAIL bp_hold%0d: got v/r0/r1=%b id=%b out=%h want 100 id=%b out=%h",
                         c, {rsp_valid, req0_ready, req1_ready}, rsp_id, rsp_out, held_id, held[31:0]);
            else n_pass++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0001)
            $display("FAIL bp_release: got busy/v/r0/r1=%b want 0001", {busy, rsp_valid, req0_ready, req1_ready});
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int          ng;
        int          nr;
        logic [31:0] outs[2];
        logic        ids[2];
        logic [1:0]  zs;
        logic [1:0]  ns;
        do_reset();
        rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 32'hFFFFFFFF; req1_b = 32'h80000000; req1_op = 3'd0;
        ng = 0;
        nr = 0;
        zs = '1;
        ns = '0;
        for (int c = 0; c < 20 && nr < 2; c++) begin
            @(negedge clk);
            if (rsp_valid) begin outs[nr] = rsp_out; ids[nr] = rsp_id; zs[nr] = rsp_zerof; ns[nr] = rsp_negf; nr++; end
            if (req0_ready) $display("FAIL b2b_port0: port 0 granted with no request");
            if (req1_ready) begin
                ng++;
                step();
                if (ng == 1) begin req1_a = 32'h12345678; req1_b = 32'hFFFFFFFF; end
                else req1_valid = 1'b0;
            end else begin
                step();
            end
        end
        n_checks++;
        if (ng != 2 || nr != 2)
            $display("FAIL b2b_count: got grants=%0d responses=%0d want 2 and 2", ng, nr);
        else n_pass++;
        if (nr == 2) begin
            n_checks++;
            if ({ids[0], ids[1], outs[0], outs[1], zs, ns} !== {2'b11, 32'h80000000, 32'h12345678, 2'b00, 2'b01})
                $display("FAIL b2b_rsp: got ids=%b%b outs=%h,%h z=%b n=%b want ids=11 outs=80000000,12345678 z=00 n=01(bit0=first)",
                         ids[0], ids[1], outs[0], outs[1], zs, ns);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = 3'd2;
        @(negedge clk);
        step();
        req0_valid = 1'b0;
        step();
        step();
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 3'd2;
        @(negedge clk);
        n_checks++;
        if (req1_ready !== 1'b1)
            $display("FAIL rmid_grant1: got rdy1=%b want 1", req1_ready);
        else n_pass++;
        step();
        req1_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, rsp_valid} !== 2'b00)
            $display("FAIL rmid_async: got busy/v=%b want 00", {busy, rsp_valid});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen = seen | rsp_valid | busy;
        end
        n_checks++;
        if (seen !== 1'b0)
            $display("FAIL rmid_no_rsp: got activity=%b want 0", seen);
        else n_pass++;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL rmid_next_grant: got rdy0/rdy1=%b want 10", {req0_ready, req1_ready});
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_stability();
        logic        seen;
        logic        saw0;
        logic        got1;
        logic        gotr;
        logic        r_id;
        logic [31:0] r_out;
        logic [35:0] e;
        do_reset();
        req1_valid = 1'b1; req1_a = 32'h0000000A; req1_b = 32'h00000003; req1_op = 3'd3;
        @(negedge clk);
        step();
        req1_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        n_checks++;
        if (!seen) $display("FAIL stab_first_rsp: got no response within 5 cycles want one");
        else n_pass++;
        req0_valid = 1'b1; req0_a = 32'h11111111; req0_b = 32'h22222222; req0_op = 3'd1;
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
        e = alu_ref(req1_op, req1_a, req1_b);
        saw0 = 1'b0;
        step();
        @(negedge clk);
        saw0 = saw0 | req0_ready | req1_ready;
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        saw0 = saw0 | req0_ready | req1_ready;
        n_checks++;
        if (saw0 !== 1'b0) $display("FAIL stab_resp_ready: got a ready in RESP want none");
        else n_pass++;
        rsp_ready = 1'b1;
        got1 = 1'b0;
        gotr = 1'b0;
        r_id = 1'b0;
        r_out = '0;
        for (int c = 0; c < 10 && !gotr; c++) begin
            @(negedge clk);
            if (rsp_valid) begin gotr = 1'b1; r_id = rsp_id; r_out = rsp_out; end
            if (req0_ready) saw0 = 1'b1;
            if (req1_ready) begin
                got1 = 1'b1;
                step();
                req1_valid = 1'b0;
            end
        end
        n_checks++;
        if ({saw0, got1, gotr, r_id} !== 4'b0111 || r_out !== e[31:0])
            $display("FAIL stab_port1: got saw0=%b grant1=%b rsp=%b id=%b out=%h want 0 1 1 1 out=%h",
                     saw0, got1, gotr, r_id, r_out, e[31:0]);
        else n_pass++;
        clear_inputs();
    endtask

    // Transaction-level reference: an operation occupies the ALU from grant until its response is taken.
    task automatic test_random();
        logic [36:0] q[$];
        logic        m_free, m_computing, m_last;
        logic        e0, e1, acc0, acc1;
        logic [35:0] r;
        do_reset();
        m_free = 1'b1;
        m_computing = 1'b0;
        m_last = 1'b1;
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid || acc0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 7) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid || acc1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 7) == 0) begin
                req1_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e0 = m_free && req0_valid && (!req1_valid || m_last);
            e1 = m_free && req1_valid && (!req0_valid || !m_last);
            n_checks++;
            if ({req0_ready, req1_ready} !== {e0, e1})
                $display("FAIL rnd_ready c%0d: got rdy0/rdy1=%b want %b", c, {req0_ready, req1_ready}, {e0, e1});
            else n_pass++;
            n_checks++;
            if (rsp_valid !== (!m_free && !m_computing))
                $display("FAIL rnd_rspv c%0d: got %b want %b", c, rsp_valid, !m_free && !m_computing);
            else n_pass++;
            if (!m_free && !m_computing && q.size() > 0) begin
                n_checks++;
                if ({rsp_id, rsp_carry, rsp_overf, rsp_negf, rsp_zerof, rsp_out} !== q[0])
                    $display("FAIL rnd_rsp c%0d: got id=%b cvnz=%b out=%h want id=%b cvnz=%b out=%h", c,
                             rsp_id, {rsp_carry, rsp_overf, rsp_negf, rsp_zerof}, rsp_out, q[0][36], q[0][35:32], q[0][31:0]);
                else n_pass++;
            end
            if (m_free) begin
                if (e0) begin r = alu_ref(req0_op, req0_a, req0_b); q.push_back({1'b0, r}); end
                if (e1) begin r = alu_ref(req1_op, req1_a, req1_b); q.push_back({1'b1, r}); end
                if (e0 || e1) begin m_free = 1'b0; m_computing = 1'b1; end
            end else if (m_computing) begin
                m_computing = 1'b0;
                m_last = q[0][36];
            end else if (rsp_ready) begin
                void'(q.pop_front());
                m_free = 1'b1;
            end
            acc0 = e0;
            acc1 = e1;
            step();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_stability();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
